// File: rtl/cart_map_mux.sv
// cart_map_mux: N-channel cartridge-mapper bus selector between the SNES core and the
// ROM/BSRAM ports. Channel 0 is the default mapper; channels 1..N_CH-1 are coprocessor
// mappers requested one-hot on map_active. A selection change first drains the old
// mapper's bus strobes, then forces the bus idle for GUARD_CYC cycles, then switches.
//
// Ports:
//   mclk, rst                       clock, asynchronous active-high reset
//   map_active                      one-hot mapper request (bit k -> channel k+1)
//   ch_*                            per-channel core/ROM/BSRAM signals, channel i at slice i
//   di, irq_n                       CPU read data / IRQ to the core
//   rom_*, bsram_*                  muxed ROM and BSRAM ports
//   sel, switching                  selected channel, high while draining or guarding
//   map_err, drain_to               sticky multi-hot and drain-timeout flags
//   turbo_allow                     CPU turbo permitted for the selected channel
module cart_map_mux #(
  parameter int unsigned     N_CH       = 7,
  parameter int unsigned     ROM_AW     = 24,
  parameter int unsigned     BSRAM_AW   = 20,
  parameter int unsigned     GUARD_CYC  = 2,
  parameter int unsigned     DRAIN_MAX  = 255,
  parameter logic [N_CH-1:0] TURBO_MASK = 7'h0A
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [N_CH-2:0]          map_active,
  input  logic [N_CH*8-1:0]        ch_do,
  input  logic [N_CH-1:0]          ch_irq_n,
  input  logic [N_CH*ROM_AW-1:0]   ch_rom_addr,
  input  logic [N_CH*16-1:0]       ch_rom_d,
  input  logic [N_CH-1:0]          ch_rom_ce_n,
  input  logic [N_CH-1:0]          ch_rom_oe_n,
  input  logic [N_CH-1:0]          ch_rom_we_n,
  input  logic [N_CH-1:0]          ch_rom_word,
  input  logic [N_CH*BSRAM_AW-1:0] ch_bsram_addr,
  input  logic [N_CH*8-1:0]        ch_bsram_d,
  input  logic [N_CH-1:0]          ch_bsram_ce_n,
  input  logic [N_CH-1:0]          ch_bsram_oe_n,
  input  logic [N_CH-1:0]          ch_bsram_we_n,
  output logic [7:0]               di,
  output logic                     irq_n,
  output logic [ROM_AW-1:0]        rom_addr,
  output logic [15:0]              rom_d,
  output logic                     rom_ce_n,
  output logic                     rom_oe_n,
  output logic                     rom_we_n,
  output logic                     rom_word,
  output logic [BSRAM_AW-1:0]      bsram_addr,
  output logic [7:0]               bsram_d,
  output logic                     bsram_ce_n,
  output logic                     bsram_oe_n,
  output logic                     bsram_we_n,
  output logic [3:0]               sel,
  output logic                     switching,
  output logic                     map_err,
  output logic                     drain_to,
  output logic                     turbo_allow
);

  typedef enum logic [1:0] {StRun, StDrain, StGuard} state_e;

  state_e     state_q;
  logic [3:0] sel_q;
  logic [3:0] nxt_q;
  logic [7:0] drain_cnt_q;
  logic [7:0] guard_cnt_q;
  logic       map_err_q;
  logic       drain_to_q;

  logic [3:0] target;
  logic [4:0] req_cnt;
  logic       multi_hot;
  logic       sel_quiet;
  logic       bus_idle;

  // Requested channel; a multi-hot request falls back to the default channel.
  always_comb begin
    target  = '0;
    req_cnt = '0;
    for (int k = 0; k < N_CH - 1; k++) begin
      if (map_active[k]) begin
        target  = 4'(k + 1);
        req_cnt = req_cnt + 5'd1;
      end
    end
    multi_hot = (req_cnt > 5'd1);
    if (multi_hot) begin
      target = '0;
    end
  end

  // The old mapper is safe to release once it is neither selecting nor writing either memory.
  always_comb begin
    sel_quiet = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == 4'(i)) begin
        sel_quiet = ch_rom_ce_n[i] & ch_rom_we_n[i] & ch_bsram_ce_n[i] & ch_bsram_we_n[i];
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      sel_q       <= '0;
      nxt_q       <= '0;
      drain_cnt_q <= '0;
      guard_cnt_q <= '0;
      map_err_q   <= 1'b0;
      drain_to_q  <= 1'b0;
    end else begin
      if (multi_hot) begin
        map_err_q <= 1'b1;
      end
      unique case (state_q)
        StRun: begin
          if (target != sel_q) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (target == sel_q) begin
            // Request withdrawn before the switch happened.
            state_q <= StRun;
          end else if (sel_quiet) begin
            nxt_q       <= target;
            guard_cnt_q <= '0;
            state_q     <= StGuard;
          end else if (drain_cnt_q == 8'(DRAIN_MAX - 1)) begin
            // Mapper never released the bus: force the switch and record it.
            drain_to_q  <= 1'b1;
            nxt_q       <= target;
            guard_cnt_q <= '0;
            state_q     <= StGuard;
          end else begin
            drain_cnt_q <= drain_cnt_q + 8'd1;
          end
        end
        StGuard: begin
          if (guard_cnt_q == 8'(GUARD_CYC - 1)) begin
            sel_q   <= nxt_q;
            state_q <= StRun;
          end else begin
            guard_cnt_q <= guard_cnt_q + 8'd1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Bus is parked idle during reset and throughout the guard window (also masks IRQ).
  assign bus_idle = rst | (state_q == StGuard);

  always_comb begin
    di          = 8'hFF;
    irq_n       = 1'b1;
    rom_addr    = '0;
    rom_d       = '0;
    rom_ce_n    = 1'b1;
    rom_oe_n    = 1'b1;
    rom_we_n    = 1'b1;
    rom_word    = 1'b0;
    bsram_addr  = '0;
    bsram_d     = '0;
    bsram_ce_n  = 1'b1;
    bsram_oe_n  = 1'b1;
    bsram_we_n  = 1'b1;
    turbo_allow = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == 4'(i)) begin
        turbo_allow = ~TURBO_MASK[i];
        if (!bus_idle) begin
          di         = ch_do[i*8 +: 8];
          irq_n      = ch_irq_n[i];
          rom_addr   = ch_rom_addr[i*ROM_AW +: ROM_AW];
          rom_d      = ch_rom_d[i*16 +: 16];
          rom_ce_n   = ch_rom_ce_n[i];
          rom_oe_n   = ch_rom_oe_n[i];
          rom_we_n   = ch_rom_we_n[i];
          rom_word   = ch_rom_word[i];
          bsram_addr = ch_bsram_addr[i*BSRAM_AW +: BSRAM_AW];
          bsram_d    = ch_bsram_d[i*8 +: 8];
          bsram_ce_n = ch_bsram_ce_n[i];
          bsram_oe_n = ch_bsram_oe_n[i];
          bsram_we_n = ch_bsram_we_n[i];
        end
      end
    end
  end

  assign sel       = sel_q;
  assign switching = (state_q != StRun);
  assign map_err   = map_err_q;
  assign drain_to  = drain_to_q;

endmodule

// File: tb/tb_cart_map_mux.sv
module tb_cart_map_mux;
  localparam int N   = 7;
  localparam int RAW = 24;
  localparam int BAW = 20;
  localparam int GC  = 2;
  localparam int DM  = 255;
  localparam logic [N-1:0] TM = 7'h0A;
  localparam int OW  = 92;

  logic mclk, rst;
  logic [N-2:0] map_active;

  // Per-channel stimulus as arrays, packed into the DUT's flat buses below.
  logic [7:0]     c_do[N];
  logic           c_irq[N];
  logic [RAW-1:0] c_ra[N];
  logic [15:0]    c_rd[N];
  logic           c_rce[N], c_roe[N], c_rwe[N], c_rw[N];
  logic [BAW-1:0] c_ba[N];
  logic [7:0]     c_bd[N];
  logic           c_bce[N], c_boe[N], c_bwe[N];

  logic [N*8-1:0]   ch_do, ch_bsram_d;
  logic [N-1:0]     ch_irq_n, ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word;
  logic [N-1:0]     ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [N*RAW-1:0] ch_rom_addr;
  logic [N*16-1:0]  ch_rom_d;
  logic [N*BAW-1:0] ch_bsram_addr;

  logic [7:0] di, bsram_d;
  logic irq_n, rom_ce_n, rom_oe_n, rom_we_n, rom_word, bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [RAW-1:0] rom_addr;
  logic [15:0] rom_d;
  logic [BAW-1:0] bsram_addr;
  logic [3:0] sel;
  logic switching, map_err, drain_to, turbo_allow;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_do[i*8 +: 8]           = c_do[i];
      ch_irq_n[i]               = c_irq[i];
      ch_rom_addr[i*RAW +: RAW] = c_ra[i];
      ch_rom_d[i*16 +: 16]      = c_rd[i];
      ch_rom_ce_n[i]            = c_rce[i];
      ch_rom_oe_n[i]            = c_roe[i];
      ch_rom_we_n[i]            = c_rwe[i];
      ch_rom_word[i]            = c_rw[i];
      ch_bsram_addr[i*BAW +: BAW] = c_ba[i];
      ch_bsram_d[i*8 +: 8]      = c_bd[i];
      ch_bsram_ce_n[i]          = c_bce[i];
      ch_bsram_oe_n[i]          = c_boe[i];
      ch_bsram_we_n[i]          = c_bwe[i];
    end
  end

  cart_map_mux #(
    .N_CH(N), .ROM_AW(RAW), .BSRAM_AW(BAW), .GUARD_CYC(GC), .DRAIN_MAX(DM), .TURBO_MASK(TM)
  ) dut (
    .mclk(mclk), .rst(rst), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr), .ch_rom_d(ch_rom_d),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_we_n(ch_rom_we_n),
    .ch_rom_word(ch_rom_word), .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n),
    .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_d(rom_d), .rom_ce_n(rom_ce_n),
    .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .rom_word(rom_word), .bsram_addr(bsram_addr),
    .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n),
    .bsram_we_n(bsram_we_n), .sel(sel), .switching(switching), .map_err(map_err),
    .drain_to(drain_to), .turbo_allow(turbo_allow)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0 = running, 1 = draining, 2 = guard window.
  int m_sel, m_ph, m_nxt, m_dc, m_gl;
  bit m_err, m_to;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    m_sel = 0; m_ph = 0; m_nxt = 0; m_dc = 0; m_gl = 0; m_err = 0; m_to = 0;
  endtask

  task automatic mstep();
    int ones;
    int t;
    ones = $countones(map_active);
    t = 0;
    if (ones == 1) begin
      for (int k = 0; k < N - 1; k++) if (map_active[k]) t = k + 1;
    end
    if (ones > 1) m_err = 1;
    case (m_ph)
      0: if (t != m_sel) begin m_ph = 1; m_dc = 0; end
      1: begin
        if (t == m_sel) m_ph = 0;
        else if (c_rce[m_sel] && c_rwe[m_sel] && c_bce[m_sel] && c_bwe[m_sel]) begin
          m_nxt = t; m_ph = 2; m_gl = GC;
        end else begin
          m_dc++;
          if (m_dc == DM) begin m_to = 1; m_nxt = t; m_ph = 2; m_gl = GC; end
        end
      end
      default: begin
        m_gl--;
        if (m_gl == 0) begin m_sel = m_nxt; m_ph = 0; end
      end
    endcase
  endtask

  function automatic logic [OW-1:0] exp_bus();
    logic [OW-9:0] tail_free;
    int s;
    s = m_sel;
    if (rst || m_ph == 2)
      tail_free = {1'b1, 24'h0, 16'h0, 4'b1110, 20'h0, 8'h0, 3'b111, 8'h0};
    else
      tail_free = {c_irq[s], c_ra[s], c_rd[s], c_rce[s], c_roe[s], c_rwe[s], c_rw[s],
                   c_ba[s], c_bd[s], c_bce[s], c_boe[s], c_bwe[s], 8'h0};
    tail_free[7:0] = {4'(m_sel), (m_ph != 0), m_err, m_to, ~TM[s]};
    return {((rst || m_ph == 2) ? 8'hFF : c_do[s]), tail_free};
  endfunction

  logic [OW-1:0] act_bus;
  assign act_bus = {di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n, rom_word,
                    bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n,
                    sel, switching, map_err, drain_to, turbo_allow};

  // One clock: compare everything against the model, then advance both across the edge.
  task automatic cyc();
    #1 chk("outs", act_bus, exp_bus());
    @(posedge mclk);
    mstep();
    @(negedge mclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mreset();
    #1 chk("reset_outs", act_bus, exp_bus());
    @(posedge mclk);
    @(negedge mclk);
    rst = 1'b0;
  endtask

  task automatic set_idle_all();
    for (int i = 0; i < N; i++) begin
      c_do[i] = 8'(8'h11 * (i + 1));
      c_irq[i] = 1'b1;
      c_ra[i] = 24'(24'h010203 * (i + 1));
      c_rd[i] = 16'(16'h0A0B * (i + 1));
      c_rce[i] = 1'b1; c_roe[i] = 1'b1; c_rwe[i] = 1'b1; c_rw[i] = 1'b1;
      c_ba[i] = 20'(20'h01234 * (i + 1));
      c_bd[i] = 8'(8'h21 + i);
      c_bce[i] = 1'b1; c_boe[i] = 1'b1; c_bwe[i] = 1'b1;
    end
  endtask

  task automatic rand_chans();
    for (int i = 0; i < N; i++) begin
      c_do[i] = 8'($urandom); c_irq[i] = 1'($urandom);
      c_ra[i] = 24'($urandom); c_rd[i] = 16'($urandom);
      c_rce[i] = ($urandom_range(0, 3) != 0); c_roe[i] = 1'($urandom);
      c_rwe[i] = ($urandom_range(0, 3) != 0); c_rw[i] = 1'($urandom);
      c_ba[i] = 20'($urandom); c_bd[i] = 8'($urandom);
      c_bce[i] = ($urandom_range(0, 3) != 0); c_boe[i] = 1'($urandom);
      c_bwe[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  typedef struct {
    logic [N-2:0] ma;
    logic [3:0]   exp_sel;
    logic         exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int dc;
    bit found;
    int r;

    tbl[0] = '{ma: 6'b000000, exp_sel: 4'd0, exp_err: 1'b0};
    tbl[1] = '{ma: 6'b000001, exp_sel: 4'd1, exp_err: 1'b0};
    tbl[2] = '{ma: 6'b000100, exp_sel: 4'd3, exp_err: 1'b0};
    tbl[3] = '{ma: 6'b100000, exp_sel: 4'd6, exp_err: 1'b0};
    tbl[4] = '{ma: 6'b010010, exp_sel: 4'd0, exp_err: 1'b1};
    tbl[5] = '{ma: 6'b111111, exp_sel: 4'd0, exp_err: 1'b1};

    rst = 1'b1;
    map_active = '0;
    set_idle_all();
    mreset();
    @(negedge mclk);
    do_reset();

    // Reset release: channel 0 passes straight through.
    c_ra[0] = 24'h00_8000;
    #1 chk("t1_rom_addr", rom_addr, 24'h00_8000);
    chk("t1_sel", sel, 4'd0);
    chk("t1_switching", switching, 1'b0);
    chk("t1_turbo", turbo_allow, 1'b1);
    cyc();

    // Switch 0 -> 3 with an idle channel 0: one drain cycle, two guard cycles.
    c_irq[0] = 1'b0;
    map_active = 6'b000100;
    cyc();
    #1 chk("t2_drain_sw", switching, 1'b1);
    chk("t2_drain_addr", rom_addr, 24'h00_8000);
    cyc();
    for (int g = 0; g < GC; g++) begin
      #1 chk("t2_guard_ce", rom_ce_n, 1'b1);
      chk("t2_guard_di", di, 8'hFF);
      chk("t2_guard_irq", irq_n, 1'b1);
      chk("t2_guard_sw", switching, 1'b1);
      cyc();
    end
    #1 chk("t2_sel", sel, 4'd3);
    chk("t2_turbo", turbo_allow, 1'b0);
    chk("t2_switching", switching, 1'b0);
    c_irq[0] = 1'b1;

    // Switch 3 -> 0 while channel 3 holds its ROM select for 10 cycles.
    map_active = '0;
    c_rce[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t3_follow_ce", rom_ce_n, 1'b0);
      chk("t3_follow_addr", rom_addr, c_ra[3]);
      cyc();
    end
    c_rce[3] = 1'b1;
    cyc();
    for (int g = 0; g < GC; g++) begin
      #1 chk("t3_guard_di", di, 8'hFF);
      cyc();
    end
    #1 chk("t3_sel", sel, 4'd0);
    chk("t3_drain_to", drain_to, 1'b0);

    // Drain timeout: channel 3 never releases the ROM.
    map_active = 6'b000100;
    run(2 + GC);
    #1 chk("t4_sel3", sel, 4'd3);
    c_rce[3] = 1'b0;
    c_do[3] = 8'h33;
    map_active = '0;
    dc = 0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc();
      #1;
      if (switching && rom_ce_n) found = 1;
      else if (switching) dc++;
    end
    chk("t4_guard_reached", found, 1'b1);
    chk("t4_drain_cycles", dc, DM);
    chk("t4_drain_to", drain_to, 1'b1);
    run(GC);
    #1 chk("t4_sel0", sel, 4'd0);
    c_rce[3] = 1'b1;

    // Multi-hot request: sticky error, no switch.
    map_active = 6'b010010;
    #1 chk("t5_err_before", map_err, 1'b0);
    cyc();
    #1 chk("t5_err_set", map_err, 1'b1);
    chk("t5_sel", sel, 4'd0);
    map_active = '0;
    run(3);
    #1 chk("t5_err_sticky", map_err, 1'b1);
    chk("t5_to_sticky", drain_to, 1'b1);

    // Reset in the middle of a guard window toward channel 5.
    do_reset();
    #1 chk("t6_err_clr", map_err, 1'b0);
    chk("t6_to_clr", drain_to, 1'b0);
    map_active = 6'b010000;
    run(3);
    #1 chk("t6_in_guard", switching, 1'b1);
    rst = 1'b1;
    mreset();
    #1 chk("t6_rst_di", di, 8'hFF);
    chk("t6_rst_ce", rom_ce_n, 1'b1);
    chk("t6_rst_sw", switching, 1'b0);
    chk("t6_rst_sel", sel, 4'd0);
    map_active = '0;
    @(posedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    #1 chk("t6_post_sel", sel, 4'd0);
    chk("t6_post_sw", switching, 1'b0);
    cyc();

    // Request decode table.
    foreach (tbl[v]) begin
      do_reset();
      map_active = tbl[v].ma;
      run(6);
      #1 chk("tbl_sel", sel, tbl[v].exp_sel);
      chk("tbl_err", map_err, tbl[v].exp_err);
      map_active = '0;
      run(6);
    end

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_chans();
      r = $urandom_range(0, 15);
      if (r >= 8 && r < 14) begin
        map_active = '0;
        map_active[$urandom_range(0, N - 2)] = 1'b1;
      end else if (r == 14) begin
        map_active = '0;
      end else if (r == 15 && $urandom_range(0, 3) == 0) begin
        map_active = 6'($urandom);
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
